// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: round-robin arbiter that frames a 32-bit channel word into 7 UART bytes
module uart_frame_scheduler #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    input  logic [31:0] word2,
    output logic [2:0]  req_ack,
    output logic [7:0]  data,
    output logic        data_rdy,
    input  logic        transm_rdy,
    output logic        busy,
    output logic        ack_err,
    output logic [15:0] frame_cnt
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t        r_state;
    logic [1:0]    r_ptr;
    logic [1:0]    r_ch;
    logic [2:0]    r_idx;
    logic [31:0]   r_word;
    logic [7:0]    r_chk;
    logic [TW-1:0] r_tmo;

    logic          w_hit;
    logic [1:0]    w_c1;
    logic [1:0]    w_c2;
    logic [1:0]    w_gch;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;

    // Round-robin pick: first requester at ptr, ptr+1, ptr+2 (mod 3)
    always_comb begin
        w_c1   = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
        w_c2   = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
        w_hit  = |req;
        w_gch  = req[r_ptr] ? r_ptr : req[w_c1] ? w_c1 : w_c2;
        w_word = (w_gch == 2'd0) ? word0 : (w_gch == 2'd1) ? word1 : word2;
    end

    // Byte selected by the frame index from the latched channel and word
    always_comb begin
        w_byte = (r_idx == 3'd0) ? SYNC_BYTE :
                 (r_idx == 3'd1) ? {6'd0, r_ch} :
                 (r_idx == 3'd2) ? r_word[31:24] :
                 (r_idx == 3'd3) ? r_word[23:16] :
                 (r_idx == 3'd4) ? r_word[15:8] :
                 (r_idx == 3'd5) ? r_word[7:0] : r_chk;
    end

    // Frame FSM: grant, strobe each byte, wait for transmitter accept and completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_ch      <= 2'd0;
            r_idx     <= 3'd0;
            r_word    <= 32'd0;
            r_chk     <= 8'd0;
            r_tmo     <= '0;
            req_ack   <= 3'd0;
            data      <= 8'd0;
            data_rdy  <= 1'b0;
            busy      <= 1'b0;
            ack_err   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            req_ack  <= 3'd0;
            data_rdy <= 1'b0;
            case (r_state)
                IDLE: if (w_hit) begin
                    r_ch    <= w_gch;
                    r_word  <= w_word;
                    r_chk   <= {6'd0, w_gch} ^ w_word[31:24] ^ w_word[23:16] ^ w_word[15:8] ^ w_word[7:0];
                    req_ack <= 3'd1 << w_gch;
                    r_idx   <= 3'd0;
                    r_ptr   <= (w_gch == 2'd2) ? 2'd0 : w_gch + 2'd1;
                    busy    <= 1'b1;
                    r_state <= SEND;
                end
                SEND: if (transm_rdy) begin
                    data     <= w_byte;
                    data_rdy <= 1'b1;
                    r_tmo    <= '0;
                    r_state  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!transm_rdy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
                        ack_err <= 1'b1;
                        r_state <= SEND;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                WAIT_DONE: if (transm_rdy) begin
                    if (r_idx == 3'd6) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= SEND;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb_uart_frame_scheduler: scoreboard bench with a model transmitter for uart_frame_scheduler
module tb_uart_frame_scheduler;
    localparam logic [7:0] SB = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'd0;
    logic [31:0] word0 = 32'd0;
    logic [31:0] word1 = 32'd0;
    logic [31:0] word2 = 32'd0;
    logic        transm_rdy = 1'b1;
    logic [2:0]  req_ack;
    logic [7:0]  data;
    logic        data_rdy;
    logic        busy;
    logic        ack_err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_b[$];
    logic [2:0] exp_g[$];
    int gnt_cnt = 0;
    int drdy_cnt = 0;
    bit stuck = 1'b0;
    int slow = 2;
    int lo = 0;
    logic [7:0] last = 8'd0;
    bit prev_drdy = 1'b0;

    always #5 clk = ~clk;

    uart_frame_scheduler dut (
        .clk(clk), .rst(rst), .req(req),
        .word0(word0), .word1(word1), .word2(word2),
        .req_ack(req_ack), .data(data), .data_rdy(data_rdy),
        .transm_rdy(transm_rdy), .busy(busy), .ack_err(ack_err),
        .frame_cnt(frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic push_frame(input logic [1:0] c, input logic [31:0] w);
        logic [7:0] ch;
        ch = {6'd0, c};
        exp_g.push_back(3'd1 << c);
        exp_b.push_back(SB);
        exp_b.push_back(ch);
        exp_b.push_back(w[31:24]);
        exp_b.push_back(w[23:16]);
        exp_b.push_back(w[15:8]);
        exp_b.push_back(w[7:0]);
        exp_b.push_back(ch ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
    endtask

    task automatic set_word(input logic [1:0] c, input logic [31:0] w);
        if (c == 2'd0) word0 = w;
        else if (c == 2'd1) word1 = w;
        else word2 = w;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic chk_reset;
        check("rst_req_ack", req_ack, 0);
        check("rst_data", data, 0);
        check("rst_data_rdy", data_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
    endtask

    task automatic wait_cnt(input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (frame_cnt != target && n < budget) begin
            tick;
            n++;
        end
        check("frame_cnt", frame_cnt, target);
    endtask

    // Grant on an idle transmitter, then check ack and SYNC-strobe latency
    task automatic run_frame(input logic [1:0] c, input logic [31:0] w);
        push_frame(c, w);
        set_word(c, w);
        req = 3'd1 << c;
        tick;
        check("ack_lat", req_ack, 3'd1 << c);
        req = 3'd0;
        tick;
        check("sync_lat", {data_rdy, data}, {1'b1, SB});
    endtask

    // Monitor and model transmitter, sampled 1 time unit after each rising edge
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            last = 8'd0;
            prev_drdy = 1'b0;
        end else begin
            if (req_ack != 3'd0) begin
                gnt_cnt++;
                if (exp_g.size() == 0) check("gnt_extra", req_ack, 0);
                else check("gnt", req_ack, exp_g.pop_front());
            end
            if (data_rdy) begin
                drdy_cnt++;
                check("drdy_back2back", prev_drdy, 0);
                check("tx_idle_at_strobe", transm_rdy, 1);
                if (exp_b.size() == 0) check("byte_extra", data, 32'h100);
                else check("byte", data, exp_b.pop_front());
                last = data;
                if (!stuck) begin
                    transm_rdy = 1'b0;
                    lo = slow;
                end
            end else begin
                check("data_hold", data, last);
            end
            prev_drdy = data_rdy;
        end
        if (!data_rdy && !transm_rdy) begin
            if (lo > 0) lo--;
            else transm_rdy = 1'b1;
        end
    end

    initial begin
        int base;
        int gbase;
        int n;
        tick;
        do_reset;
        chk_reset;

        // Single request on channel 1
        gbase = gnt_cnt;
        run_frame(2'd1, 32'h12345678);
        wait_cnt(16'd1, 500);
        check("single_acks", gnt_cnt - gbase, 1);
        check("single_sb_empty", exp_b.size(), 0);

        // All channels held: round-robin 0,1,2,0,1,2
        do_reset;
        word0 = 32'hDEADBEEF;
        word1 = 32'h00FF00FF;
        word2 = 32'hCAFEF00D;
        for (int k = 0; k < 6; k++) begin
            if (k % 3 == 0) push_frame(2'd0, word0);
            else if (k % 3 == 1) push_frame(2'd1, word1);
            else push_frame(2'd2, word2);
        end
        req = 3'b111;
        gbase = gnt_cnt;
        n = 0;
        while (gnt_cnt < gbase + 6 && n < 2000) begin
            tick;
            n++;
        end
        req = 3'd0;
        check("rr_grants", gnt_cnt - gbase, 6);
        wait_cnt(16'd6, 2000);
        check("rr_sb_empty", exp_b.size() + exp_g.size(), 0);

        // Stuck transmitter: timeout after 16 cycles, same byte re-strobed
        do_reset;
        stuck = 1'b1;
        exp_g.push_back(3'b001);
        exp_b.push_back(SB);
        exp_b.push_back(SB);
        word0 = 32'h0BADF00D;
        req = 3'b001;
        tick;
        req = 3'd0;
        tick;
        check("stuck_first", data_rdy, 1);
        repeat (15) tick;
        check("ack_err_early", ack_err, 0);
        tick;
        check("ack_err_set", ack_err, 1);
        check("stuck_busy", busy, 1);
        tick;
        check("restrobe_rdy", data_rdy, 1);
        check("restrobe_data", data, SB);
        stuck = 1'b0;
        do_reset;
        check("stuck_sb_empty", exp_b.size() + exp_g.size(), 0);
        check("stuck_err_clr", ack_err, 0);

        // Slow transmitter: 8650 idle-low cycles per byte
        do_reset;
        slow = 8650;
        base = drdy_cnt;
        run_frame(2'd2, 32'hA1B2C3D4);
        wait_cnt(16'd1, 70000);
        check("slow_strobes", drdy_cnt - base, 7);
        slow = 2;

        // Reset while byte 3 of a frame is in flight
        do_reset;
        slow = 3;
        word0 = 32'h5A6B7C8D;
        exp_g.push_back(3'b001);
        exp_b.push_back(SB);
        exp_b.push_back(8'h00);
        exp_b.push_back(8'h5A);
        base = drdy_cnt;
        req = 3'b001;
        tick;
        req = 3'd0;
        n = 0;
        while (drdy_cnt < base + 3 && n < 200) begin
            tick;
            n++;
        end
        check("abort_reach", drdy_cnt - base, 3);
        do_reset;
        chk_reset;
        base = drdy_cnt;
        gbase = gnt_cnt;
        repeat (20) tick;
        check("abort_no_strobe", drdy_cnt - base, 0);
        check("abort_no_ack", gnt_cnt - gbase, 0);
        check("abort_sb_empty", exp_b.size() + exp_g.size(), 0);
        run_frame(2'd0, 32'h01020304);
        wait_cnt(16'd1, 500);
        slow = 2;

        // frame_cnt wrap
        do_reset;
        force dut.frame_cnt = 16'hFFFE;
        #1;
        release dut.frame_cnt;
        check("preload", frame_cnt, 16'hFFFE);
        run_frame(2'd1, 32'h89ABCDEF);
        wait_cnt(16'hFFFF, 500);
        run_frame(2'd1, 32'h76543210);
        wait_cnt(16'h0000, 500);

        check("final_sb_empty", exp_b.size() + exp_g.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
